// File: rtl/rule_port_filter_pkg.sv
// Shared types and constants for the rule port-check stage.
// Provides the FIFO entry and delay-line payload structs plus fixed widths/latency.
package rule_port_filter_pkg;

   localparam int unsigned RPF_RULE_AWIDTH = 16;
   localparam int unsigned RPF_PU_LATENCY  = 12;
   localparam int unsigned RPF_PORT_W      = 16;

   // Output FIFO entry: hit=0 entries are bare end-of-packet markers
   typedef struct packed {
      logic [RPF_RULE_AWIDTH-1:0] rule_id;
      logic                       hit;
      logic                       last;
   } rpf_entry_t;

   // Delay-line payload carried alongside the port_unit lookup
   typedef struct packed {
      logic                       valid;
      logic [RPF_RULE_AWIDTH-1:0] rule_id;
      logic                       last;
   } rpf_pipe_t;

endpackage

// File: rtl/rule_port_filter_fifo.sv
// rpf_fifo: synchronous show-ahead FIFO of rpf_entry_t.
// Storage array has a 1-cycle registered read into a head register, so the
// head is presented registered and is held while not popped.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   push_i/push_data_i write one entry
//   pop_i              consume the head (ignored when head invalid)
//   head_o/head_valid_o registered head entry and its valid
//   occupancy_o        entries held (array + head), registered
module rpf_fifo
   import rule_port_filter_pkg::*;
#(
   parameter int unsigned DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  rpf_entry_t               push_data_i,
   input  logic                     pop_i,
   output rpf_entry_t               head_o,
   output logic                     head_valid_o,
   output logic [$clog2(DEPTH):0]   occupancy_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   rpf_entry_t       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    mem_cnt_q, mem_cnt_d;
   logic [CW-1:0]    occ_q, occ_d;
   rpf_entry_t       head_q, head_d;
   logic             head_valid_q, head_valid_d;
   logic             pop_eff;
   logic             load;

   // Head refill: pull from the array whenever the head is empty or leaving
   always_comb begin
      head_d       = head_q;
      head_valid_d = head_valid_q;
      pop_eff      = pop_i & head_valid_q;
      load         = (mem_cnt_q != '0) && (!head_valid_q || pop_eff);
      if (load) begin
         head_d       = mem_q[rd_ptr_q];
         head_valid_d = 1'b1;
      end else if (pop_eff) begin
         head_d       = '0;
         head_valid_d = 1'b0;
      end
      mem_cnt_d = mem_cnt_q + CW'(push_i) - CW'(load);
      occ_d     = occ_q + CW'(push_i) - CW'(pop_eff);
      wr_ptr_d  = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = load   ? rd_ptr_q + AW'(1) : rd_ptr_q;
   end

   // Control state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         mem_cnt_q    <= '0;
         occ_q        <= '0;
         head_q       <= '0;
         head_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         mem_cnt_q    <= mem_cnt_d;
         occ_q        <= occ_d;
         head_q       <= head_d;
         head_valid_q <= head_valid_d;
      end
   end

   // Storage array, no reset needed: contents are qualified by the counters
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o       = head_q;
   assign head_valid_o = head_valid_q;
   assign occupancy_o  = occ_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && (occ_q == CW'(DEPTH))));

endmodule

// File: rtl/rule_port_filter.sv
// rule_port_filter: port-check stage after rule/port-group lookup.
// Issues each accepted candidate rule to port_unit, realigns the fixed-latency
// port_match with the rule through a delay line, and pushes matched rules plus
// one EOP marker per packet into a show-ahead output FIFO. Credits guarantee an
// accepted beat always finds FIFO space.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_* / in_valid / in_ready          candidate rule stream (in_ready combinational)
//   pu_* / pu_pg_valid                  request to port_unit (registered)
//   pu_port_match                       port_unit result, PU_LATENCY after pu_pg_valid
//   out_* / out_valid / out_ready       FIFO head (registered)
// Optional: define RPF_STATS_EN to add stat_in/stat_hit/stat_drop/stat_eop counters.
module rule_port_filter
   import rule_port_filter_pkg::*;
#(
   parameter int unsigned PG_AWIDTH  = 8,
   parameter int unsigned FIFO_DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [RPF_RULE_AWIDTH-1:0] in_rule_id,
   input  logic [PG_AWIDTH-1:0]       in_pg,
   input  logic [RPF_PORT_W-1:0]      in_src_port,
   input  logic [RPF_PORT_W-1:0]      in_dst_port,
   input  logic                       in_tcp,
   input  logic                       in_last,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [PG_AWIDTH-1:0]       pu_pg,
   output logic                       pu_pg_valid,
   output logic [RPF_PORT_W-1:0]      pu_src_port,
   output logic [RPF_PORT_W-1:0]      pu_dst_port,
   output logic                       pu_tcp,
   input  logic                       pu_port_match,
   output logic [RPF_RULE_AWIDTH-1:0] out_rule_id,
   output logic                       out_hit,
   output logic                       out_last,
   output logic                       out_valid,
   input  logic                       out_ready
`ifdef RPF_STATS_EN
   ,
   output logic [31:0]                stat_in,
   output logic [31:0]                stat_hit,
   output logic [31:0]                stat_drop,
   output logic [31:0]                stat_eop
`endif
);

   localparam int unsigned PU_LATENCY = RPF_PU_LATENCY;
   localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;

   logic [CW-1:0]              credits_q, credits_d;
   logic [RPF_RULE_AWIDTH-1:0] iss_rule_q;
   logic                       iss_last_q;
   rpf_pipe_t                  pipe_q [PU_LATENCY];
   rpf_pipe_t                  pipe_out;
   rpf_entry_t                 push_data;
   rpf_entry_t                 head;
   logic                       head_valid;
   logic [CW-1:0]              occupancy;
   logic                       accept, push, drop, pop;

   assign in_ready = (credits_q != '0);
   assign accept   = in_valid & in_ready;
   assign pop      = head_valid & out_ready;

   // Issue registers: one-cycle pu_pg_valid pulse, pu_* hold otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pu_pg       <= '0;
         pu_pg_valid <= 1'b0;
         pu_src_port <= '0;
         pu_dst_port <= '0;
         pu_tcp      <= 1'b0;
         iss_rule_q  <= '0;
         iss_last_q  <= 1'b0;
      end else begin
         pu_pg_valid <= accept;
         if (accept) begin
            pu_pg       <= in_pg;
            pu_src_port <= in_src_port;
            pu_dst_port <= in_dst_port;
            pu_tcp      <= in_tcp;
            iss_rule_q  <= in_rule_id;
            iss_last_q  <= in_last;
         end
      end
   end

   // Delay line fed from the issue registers so its last stage coincides
   // with the port_match produced PU_LATENCY cycles after pu_pg_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < PU_LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= '{valid: pu_pg_valid, rule_id: iss_rule_q, last: iss_last_q};
         for (int unsigned i = 1; i < PU_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign pipe_out = pipe_q[PU_LATENCY-1];

   // Decision: push hit, push EOP marker on unmatched last, else drop
   always_comb begin
      push      = 1'b0;
      drop      = 1'b0;
      push_data = '0;
      if (pipe_out.valid) begin
         if (pu_port_match) begin
            push      = 1'b1;
            push_data = '{rule_id: pipe_out.rule_id, hit: 1'b1, last: pipe_out.last};
         end else if (pipe_out.last) begin
            push      = 1'b1;
            push_data = '{rule_id: '0, hit: 1'b0, last: 1'b1};
         end else begin
            drop = 1'b1;
         end
      end
   end

   // Credits: accept consumes, drop and pop return; simultaneous events net out
   always_comb begin
      credits_d = credits_q - CW'(accept) + CW'(drop) + CW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits_q <= CW'(FIFO_DEPTH);
      end else begin
         credits_q <= credits_d;
      end
   end

   rpf_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push),
      .push_data_i  (push_data),
      .pop_i        (pop),
      .head_o       (head),
      .head_valid_o (head_valid),
      .occupancy_o  (occupancy)
   );

   assign out_rule_id = head.rule_id;
   assign out_hit     = head.hit;
   assign out_last    = head.last;
   assign out_valid   = head_valid;

   a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
      ({1'b0, credits_q} + {1'b0, occupancy}) <= (CW+1)'(FIFO_DEPTH));

`ifdef RPF_STATS_EN
   // Saturating event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_in   <= '0;
         stat_hit  <= '0;
         stat_drop <= '0;
         stat_eop  <= '0;
      end else begin
         if (accept && (stat_in != '1))                  stat_in   <= stat_in + 32'd1;
         if (push && push_data.hit && (stat_hit != '1))  stat_hit  <= stat_hit + 32'd1;
         if (drop && (stat_drop != '1))                  stat_drop <= stat_drop + 32'd1;
         if (push && !push_data.hit && (stat_eop != '1)) stat_eop  <= stat_eop + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rule_port_filter.sv
// Scoreboard bench for rule_port_filter: directed beats push expected FIFO
// entries into a queue; a monitor pops and compares on every output handshake.
// A behavioural port_unit returns match = pg[0] twelve cycles after pu_pg_valid.
module tb_rule_port_filter;

   typedef struct packed {
      logic [15:0] rule;
      logic        hit;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in_rule_id;
   logic [7:0]  in_pg;
   logic [15:0] in_src_port, in_dst_port;
   logic        in_tcp, in_last, in_valid, in_ready;
   logic [7:0]  pu_pg;
   logic        pu_pg_valid;
   logic [15:0] pu_src_port, pu_dst_port;
   logic        pu_tcp, pu_port_match;
   logic [15:0] out_rule_id;
   logic        out_hit, out_last, out_valid, out_ready;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          stalls = 0;
   logic [11:0] mp = '0;

   always #5 clk = ~clk;

   rule_port_filter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_rule_id    (in_rule_id),
      .in_pg         (in_pg),
      .in_src_port   (in_src_port),
      .in_dst_port   (in_dst_port),
      .in_tcp        (in_tcp),
      .in_last       (in_last),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .pu_pg         (pu_pg),
      .pu_pg_valid   (pu_pg_valid),
      .pu_src_port   (pu_src_port),
      .pu_dst_port   (pu_dst_port),
      .pu_tcp        (pu_tcp),
      .pu_port_match (pu_port_match),
      .out_rule_id   (out_rule_id),
      .out_hit       (out_hit),
      .out_last      (out_last),
      .out_valid     (out_valid),
      .out_ready     (out_ready)
   );

   // Behavioural port_unit: fixed 12-cycle latency, match when pg is odd
   always @(posedge clk) mp <= {mp[10:0], pu_pg_valid & pu_pg[0]};
   assign pu_port_match = mp[11];

   // Monitor: compare each popped entry against the scoreboard head
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_entry got rule=%0d hit=%0b last=%0b, queue empty",
                     out_rule_id, out_hit, out_last);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (out_rule_id !== e.rule || out_hit !== e.hit || out_last !== e.last) begin
               errors++;
               $display("FAIL entry got {%0d,%0b,%0b} expected {%0d,%0b,%0b}",
                        out_rule_id, out_hit, out_last, e.rule, e.hit, e.last);
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [15:0] rule, input logic [7:0] pg, input logic last);
      exp_t e;
      if (pg[0]) begin
         e = '{rule: rule, hit: 1'b1, last: last};
         exp_q.push_back(e);
      end else if (last) begin
         e = '{rule: 16'd0, hit: 1'b0, last: 1'b1};
         exp_q.push_back(e);
      end
   endtask

   task automatic drive(input logic [15:0] rule, input logic [7:0] pg, input logic last);
      in_rule_id  = rule;
      in_pg       = pg;
      in_src_port = 16'h1000 + rule;
      in_dst_port = 16'h2000 + rule;
      in_tcp      = rule[0];
      in_last     = last;
      in_valid    = 1'b1;
   endtask

   // Present one beat until accepted (bounded), returns at accept edge + 1
   task automatic send(input logic [15:0] rule, input logic [7:0] pg, input logic last);
      logic r;
      bit   done = 1'b0;
      drive(rule, pg, last);
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge clk);
         r = in_ready;
         @(posedge clk);
         if (r) done = 1'b1;
         else stalls++;
      end
      if (done) push_exp(rule, pg, last);
      else check("send_timeout", 32'd0, 32'd1);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok = 1'b0;
      for (int t = 0; t < 1000 && !ok; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
      end
      check("drain", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   n;
      int   idx;
      int   seen;
      logic r;

      rst_n = 1'b0; in_valid = 1'b0; in_rule_id = '0; in_pg = '0;
      in_src_port = '0; in_dst_port = '0; in_tcp = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid",   32'(out_valid), 32'd0);
      check("rst_out_rule_id", 32'(out_rule_id), 32'd0);
      check("rst_out_hit_last", 32'({out_hit, out_last}), 32'd0);
      check("rst_pu_pg_valid", 32'(pu_pg_valid), 32'd0);
      check("rst_pu_pg",       32'(pu_pg), 32'd0);
      check("rst_in_ready",    32'(in_ready), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // T1: single matching last beat, issue fields and latency
      send(16'd5, 8'd3, 1'b1);
      check("t1_pu_pg_valid", 32'(pu_pg_valid), 32'd1);
      check("t1_pu_pg",       32'(pu_pg), 32'd3);
      check("t1_pu_src",      32'(pu_src_port), 32'h1005);
      check("t1_pu_dst",      32'(pu_dst_port), 32'h2005);
      check("t1_pu_tcp",      32'(pu_tcp), 32'd1);
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) check("t1_pg_valid_pulse", 32'(pu_pg_valid), 32'd0);
         if (out_valid) begin
            n = k;
            break;
         end
      end
      check("t1_latency", 32'(n), 32'd14);
      wait_drain();

      // T2: only the middle rule matches; unmatched last yields EOP marker
      send(16'd7, 8'd2, 1'b0);
      send(16'd8, 8'd3, 1'b0);
      send(16'd9, 8'd4, 1'b1);
      wait_drain();

      // T3: 40 non-matching non-last beats with output blocked, all dropped
      out_ready = 1'b0;
      stalls = 0;
      for (int i = 0; i < 40; i++) send(16'(100 + i), 8'h10, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      check("t3_stalls", 32'(stalls), 32'd0);
      check("t3_fifo_empty", 32'(out_valid), 32'd0);
      out_ready = 1'b1;

      // T4: 40 matching beats with output blocked, credits cap at 32
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 60; c++) begin
         if (idx < 40) drive(16'(200 + idx), 8'd1, idx == 39);
         else in_valid = 1'b0;
         @(negedge clk);
         r = in_ready & in_valid;
         @(posedge clk);
         if (r) begin
            push_exp(16'(200 + idx), 8'd1, idx == 39);
            idx++;
         end
         #1;
      end
      in_valid = 1'b0;
      check("t4_accepted", 32'(idx), 32'd32);
      check("t4_in_ready_low", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      for (int i = idx; i < 40; i++) send(16'(200 + i), 8'd1, i == 39);
      wait_drain();

      // T5: sustained accept + push + pop every cycle
      stalls = 0;
      for (int i = 0; i < 100; i++) send(16'(1000 + i), 8'd5, i == 99);
      check("t5_stalls", 32'(stalls), 32'd0);
      wait_drain();

      // T6: reset with 6 beats in flight, nothing stale may emerge
      for (int i = 0; i < 6; i++) begin
         drive(16'(300 + i), 8'd1, i == 5);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t6_pu_pg_valid", 32'(pu_pg_valid), 32'd0);
      check("t6_pu_pg",       32'(pu_pg), 32'd0);
      check("t6_out_valid",   32'(out_valid), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("t6_in_ready", 32'(in_ready), 32'd1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("t6_no_stale", 32'(seen), 32'd0);
      @(posedge clk);
      #1;

      // Recovery after reset
      send(16'd42, 8'd1, 1'b1);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
